uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte-producing requesters (for example, the button-triggered data path and an on-chip status source). Each requester presents a byte with a valid/ready handshake. The arbiter grants one requester at a time and launches the transmitter with a one-cycle start pulse. It then holds ownership until the transmitter reports frame completion, or aborts on a watchdog timeout. It sits between the requesters and the UART top's transmitter start/data inputs.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake between two requesters, the arbiter and the UART transmitter.
// The arbiter uses the slave modport. The requesters and the transmitter use the master modport.
interface uart_tx_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_done,
    input  req0_ready, req1_ready, tx_start, tx_data
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_done,
    output req0_ready, req1_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte requesters. A watchdog aborts frames that never complete.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration. Otherwise req0 has fixed priority.
module uart_tx_arbiter #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_arbiter_if.slave  bus,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       frame_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  wd_cnt_r;
  logic              tx_start_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              grant_r;
  logic              busy_r;
  logic [15:0]       frame_cnt_r;

  logic              pick1_s;
  logic              accept_s;
  logic              wd_last_s;
  logic              abort_s;

`ifdef UART_ARB_ROUND_ROBIN_EN
  logic              last_grant_r;

  // Winner select: under contention, the requester that was not served last wins.
  always_comb begin
    pick1_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      pick1_s = ~last_grant_r;
    end else begin
      pick1_s = bus.req1_valid;
    end
  end
`else
  // Winner select: req1 wins only when req0 is idle.
  always_comb begin
    pick1_s = 1'b0;
    if (bus.req1_valid && !bus.req0_valid) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
  end
`endif

  // Acceptance and abort decode. Gating with reset_n means no byte is consumed while reset is held.
  always_comb begin
    accept_s  = reset_n && (state_r == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
    wd_last_s = (wd_cnt_r == CNT_LAST);
    // Completion takes precedence over the watchdog in the same cycle.
    abort_s   = reset_n && (state_r == ST_WAIT_DONE) && wd_last_s && !bus.tx_done;
  end

  // Arbitration FSM with registered launch outputs, watchdog and frame counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      wd_cnt_r     <= {CNT_W{1'b0}};
      tx_start_r   <= 1'b0;
      tx_data_r    <= {DATA_W{1'b0}};
      grant_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_cnt_r  <= 16'd0;
`ifdef UART_ARB_ROUND_ROBIN_EN
      last_grant_r <= 1'b1;
`endif
    end else begin
      tx_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_LAUNCH;
            tx_start_r <= 1'b1;
            tx_data_r  <= pick1_s ? bus.req1_data : bus.req0_data;
            grant_r    <= pick1_s;
            busy_r     <= 1'b1;
`ifdef UART_ARB_ROUND_ROBIN_EN
            last_grant_r <= pick1_s;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          wd_cnt_r <= {CNT_W{1'b0}};
          state_r  <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.tx_done) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
          end else if (wd_last_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = accept_s & ~pick1_s;
  assign bus.req1_ready = accept_s & pick1_s;
  assign bus.tx_start   = tx_start_r;
  assign bus.tx_data    = tx_data_r;
  assign grant_id       = grant_r;
  assign busy           = busy_r;
  assign timeout_err    = abort_s;
  assign frame_cnt      = frame_cnt_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with TIMEOUT_CYCLES=16.
// Contention expectations follow UART_ARB_ROUND_ROBIN_EN.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        grant_id;
  logic        busy;
  logic        timeout_err;
  logic [15:0] frame_cnt;
  int          checks = 0;
  int          errors = 0;

  uart_tx_arbiter_if #(.DATA_W(8)) bus ();

  uart_tx_arbiter #(.DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant_id); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.req0_data  = 8'hB5;
    bus.req0_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b want 1", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1: got %b want 0", bus.req1_ready); end
    tick();
    bus.req0_valid = 1'b0;
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'hB5) begin errors++; $display("FAIL single_data: got %h want b5", bus.tx_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL single_grant: got %b want 0", grant_id); end
    tick();
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b want 0", bus.tx_start); end
    bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready_busy: got %b want 0", bus.req1_ready); end
    bus.req1_valid = 1'b0;
    repeat (6) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frames: got %0d want 1", frame_cnt); end
    checks++; if (bus.tx_data !== 8'hB5) begin errors++; $display("FAIL single_data_hold: got %h want b5", bus.tx_data); end
  endtask

  task automatic test_contention();
    logic exp_g;
    logic [7:0] exp_d;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req0_data  = 8'hAA;
    bus.req1_data  = 8'h55;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef UART_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 1);
`else
      exp_g = 1'b0;
`endif
      exp_d = exp_g ? 8'h55 : 8'hAA;
      tick();
      checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL cont_start[%0d]: got %b want 1", i, bus.tx_start); end
      checks++; if (grant_id !== exp_g) begin errors++; $display("FAIL cont_grant[%0d]: got %b want %b", i, grant_id, exp_g); end
      checks++; if (bus.tx_data !== exp_d) begin errors++; $display("FAIL cont_data[%0d]: got %h want %h", i, bus.tx_data, exp_d); end
      repeat (10) tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      if (i == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    tick();
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL cont_frames: got %0d want 4", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    bus.req1_data  = 8'h3C;
    bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL to_ready1: got %b want 1", bus.req1_ready); end
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL to_ready0: got %b want 0", bus.req0_ready); end
    tick();
    bus.req1_valid = 1'b0;
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL to_start: got %b want 1", bus.tx_start); end
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL to_grant: got %b want 1", grant_id); end
    checks++; if (bus.tx_data !== 8'h3C) begin errors++; $display("FAIL to_data: got %h want 3c", bus.tx_data); end
    for (int k = 0; k < 15; k++) begin
      tick();
      if (timeout_err !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", early); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_at_pulse: got %b want 1", busy); end
    bus.req0_data  = 8'h77;
    bus.req0_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL to_ready_wait: got %b want 0", bus.req0_ready); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_end: got %b want 0", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", busy); end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL to_frames: got %0d want 4", frame_cnt); end
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL to_next_ready: got %b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0;
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL to_next_start: got %b want 1", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h77) begin errors++; $display("FAIL to_next_data: got %h want 77", bus.tx_data); end
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL to_next_frames: got %0d want 5", frame_cnt); end
  endtask

  task automatic test_done_timeout_coincide();
    bus.req0_data  = 8'h0F;
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL co_start: got %b want 1", bus.tx_start); end
    repeat (16) tick();
    bus.tx_done = 1'b1;
    #1;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL co_no_err: got %b want 0", timeout_err); end
    tick();
    bus.tx_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL co_idle: got %b want 0", busy); end
    checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL co_frames: got %0d want 6", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    bus.req0_data  = 8'hC3;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL b2b_start[%0d]: got %b want 1", i, bus.tx_start); end
      tick();
      checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL b2b_wait[%0d]: got %b want 0", i, bus.tx_start); end
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      checks++; if ((busy !== 1'b0) || (bus.tx_start !== 1'b0)) begin errors++; $display("FAIL b2b_idle[%0d]: got busy=%b start=%b want 0 0", i, busy, bus.tx_start); end
      if (i == 19) bus.req0_valid = 1'b0;
    end
    tick();
    checks++; if (frame_cnt !== 16'd26) begin errors++; $display("FAIL b2b_frames: got %0d want 26", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bus.req1_data  = 8'hE1;
    bus.req1_valid = 1'b1;
    tick();
    bus.req1_valid = 1'b0;
    checks++; if (bus.tx_data !== 8'hE1) begin errors++; $display("FAIL rst_mid_data: got %h want e1", bus.tx_data); end
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_tx_data: got %h want 00", bus.tx_data); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_frames: got %0d want 0", frame_cnt); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_mid_grant: got %b want 0", grant_id); end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_stray_done: got %0d want 0", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_stray_busy: got %b want 0", busy); end
    bus.req0_data  = 8'hAA;
    bus.req1_data  = 8'h55;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rst_first_win: got %b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checks++; if (bus.tx_data !== 8'hAA) begin errors++; $display("FAIL rst_first_data: got %h want aa", bus.tx_data); end
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rst_after_frames: got %0d want 1", frame_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, want completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset_n        = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.tx_done    = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_done_timeout_coincide();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
